uart_core_param: RTL and testbench

Parametrised full-duplex UART core with a shared 16x-oversampling baud generator, a transmitter and a majority-vote receiver. Data width, parity and stop-bit count are configurable, and the receiver reports framing and parity errors. The core sits between the system bus/command logic and the board TX/RX pins. It is the drop-in successor to the fixed 8N1 UART top level.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_core_param_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_core_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the parametrised UART core.
// The PARITY FSM states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  // Rounded clock divider producing one tick per oversample period.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Bus-side handshake of the UART core: transmit request and receive results.
interface uart_core_param_if #(parameter int DATA_BITS = 8);

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, rx_data, rx_done, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, rx_data, rx_done, rx_frame_err, rx_parity_err
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversampling tick generator shared by TX and RX.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: transmitter and 3-sample majority-vote receiver on a shared tick.
// Define UART_PARITY_EN to enable the PARITY parameter; otherwise frames carry no parity.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  uart_core_param_if.slave bus
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

`ifdef UART_PARITY_EN
  localparam parity_t PAR_MODE = parity_t'(PARITY);
  localparam bit PAR_ON  = (PAR_MODE != PAR_NONE);
  localparam bit PAR_INV = (PAR_MODE == PAR_ODD);
`endif

  logic tick;

  uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  tx_state_t            tx_state, tx_state_nx;
  logic [3:0]           tx_tick_cnt, tx_tick_cnt_nx;
  logic [IW-1:0]        tx_bit_idx, tx_bit_idx_nx;
  logic                 tx_stop_idx, tx_stop_idx_nx;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic                 tx_nx;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_nx;
`endif

  assign tx_bit_end  = tick && (tx_tick_cnt == 4'd15);
  assign bus.tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx          <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      tx_state    <= tx_state_nx;
      tx_tick_cnt <= tx_tick_cnt_nx;
      tx_bit_idx  <= tx_bit_idx_nx;
      tx_stop_idx <= tx_stop_idx_nx;
      tx_shift    <= tx_shift_nx;
      tx          <= tx_nx;
`ifdef UART_PARITY_EN
      tx_par      <= tx_par_nx;
`endif
    end
  end

  // The line level is derived from the next state so tx moves on the same edge as tx_busy.
  always_comb begin
    tx_state_nx    = tx_state;
    tx_tick_cnt_nx = tick ? tx_tick_cnt + 4'd1 : tx_tick_cnt;
    tx_bit_idx_nx  = tx_bit_idx;
    tx_stop_idx_nx = tx_stop_idx;
    tx_shift_nx    = tx_shift;
`ifdef UART_PARITY_EN
    tx_par_nx      = tx_par;
`endif
    unique case (tx_state)
      TX_IDLE: begin
        tx_tick_cnt_nx = '0;
        if (bus.tx_start) begin
          tx_shift_nx    = bus.tx_data;
          tx_bit_idx_nx  = '0;
          tx_stop_idx_nx = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_nx      = (^bus.tx_data) ^ PAR_INV;
`endif
          tx_state_nx    = TX_START;
        end
      end
      TX_START: if (tx_bit_end) tx_state_nx = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_nx   = tx_shift >> 1;
          tx_bit_idx_nx = tx_bit_idx + 1'b1;
          if (tx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_nx = PAR_ON ? TX_PARITY : TX_STOP;
`else
            tx_state_nx = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_stop_idx_nx = 1'b1;
          if (tx_stop_idx == LAST_STOP) tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase

    unique case (tx_state_nx)
      TX_START:  tx_nx = 1'b0;
      TX_DATA:   tx_nx = tx_shift_nx[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_nx = tx_par_nx;
`endif
      default:   tx_nx = 1'b1;
    endcase
  end

  logic rx_s1, rx_s2, rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  rx_state_t            rx_state, rx_state_nx;
  logic [3:0]           rx_cnt, rx_cnt_nx;
  logic [IW-1:0]        rx_bit_idx, rx_bit_idx_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
  logic [1:0]           rx_smp, rx_smp_nx;
  logic [DATA_BITS-1:0] rx_data_nx;
  logic                 rx_done_nx, rx_frame_err_nx;
  logic                 rx_maj, rx_sample_now, rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad, rx_par_bad_nx, rx_parity_err_nx;
`endif

  // Third vote comes straight from the synchronizer on the tick at count 9.
  assign rx_maj = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s2) | (rx_smp[1] & rx_s2);
  assign rx_sample_now = tick && (rx_cnt == 4'd9);
  assign rx_bit_end    = tick && (rx_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state         <= RX_IDLE;
      rx_cnt           <= '0;
      rx_bit_idx       <= '0;
      rx_shift         <= '0;
      rx_smp           <= '0;
      bus.rx_data      <= '0;
      bus.rx_done      <= 1'b0;
      bus.rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad        <= 1'b0;
      bus.rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_state         <= rx_state_nx;
      rx_cnt           <= rx_cnt_nx;
      rx_bit_idx       <= rx_bit_idx_nx;
      rx_shift         <= rx_shift_nx;
      rx_smp           <= rx_smp_nx;
      bus.rx_data      <= rx_data_nx;
      bus.rx_done      <= rx_done_nx;
      bus.rx_frame_err <= rx_frame_err_nx;
`ifdef UART_PARITY_EN
      rx_par_bad        <= rx_par_bad_nx;
      bus.rx_parity_err <= rx_parity_err_nx;
`endif
    end
  end

`ifndef UART_PARITY_EN
  assign bus.rx_parity_err = 1'b0;
`endif

  always_comb begin
    rx_state_nx     = rx_state;
    rx_cnt_nx       = tick ? rx_cnt + 4'd1 : rx_cnt;
    rx_bit_idx_nx   = rx_bit_idx;
    rx_shift_nx     = rx_shift;
    rx_smp_nx       = rx_smp;
    rx_data_nx      = bus.rx_data;
    rx_done_nx      = 1'b0;
    rx_frame_err_nx = bus.rx_frame_err;
`ifdef UART_PARITY_EN
    rx_par_bad_nx    = rx_par_bad;
    rx_parity_err_nx = bus.rx_parity_err;
`endif
    if (tick && rx_cnt == 4'd7) rx_smp_nx[0] = rx_s2;
    if (tick && rx_cnt == 4'd8) rx_smp_nx[1] = rx_s2;

    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_fall) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (tick && rx_cnt == 4'd7 && rx_s2) begin
          rx_state_nx = RX_IDLE;
        end else if (rx_bit_end) begin
          rx_bit_idx_nx = '0;
          rx_state_nx   = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample_now) rx_shift_nx = {rx_maj, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          rx_bit_idx_nx = rx_bit_idx + 1'b1;
          if (rx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_nx = PAR_ON ? RX_PARITY : RX_STOP;
`else
            rx_state_nx = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_sample_now) rx_par_bad_nx = rx_maj != ((^rx_shift) ^ PAR_INV);
        if (rx_bit_end) rx_state_nx = RX_STOP;
      end
`endif
      RX_STOP: begin
        if (rx_sample_now) begin
          rx_done_nx      = 1'b1;
          rx_data_nx      = rx_shift;
          rx_frame_err_nx = !rx_maj;
`ifdef UART_PARITY_EN
          rx_parity_err_nx = PAR_ON && rx_par_bad;
          rx_par_bad_nx    = 1'b0;
`endif
          rx_state_nx     = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: tx looped back to rx, with an
// external driver for malformed frames; line decoder and rx_done scoreboards.
`timescale 1ns/1ps
module tb_uart_core_param;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 115200;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_PARITY_EN
  localparam int PARITY = 1;
  localparam int PBITS  = 1;
`else
  localparam int PARITY = 0;
  localparam int PBITS  = 0;
`endif
  localparam int BIT_CLKS   = 864;
  localparam int FRAME_BITS = 1 + DATA_BITS + PBITS + STOP_BITS;
  localparam int NUM_RANDOM = (PBITS != 0) ? 1 : 2;

  typedef struct {
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic rx;
  logic ext_drive = 1'b0;
  logic ext_rx = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;
  int rx_done_seen = 0;

  rx_exp_t    rx_exp[$];
  logic [7:0] tx_exp[$];

  always #5 clk = ~clk;

  assign rx = ext_drive ? ext_rx : tx;

  uart_core_param_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_core_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
    .PARITY(PARITY), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx),
    .bus (bus)
  );

  // Reference parity: even mode makes the count of ones in data+parity even.
  function automatic logic model_parity(input logic [7:0] d);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    return (PARITY == 2) ? !odd_ones : odd_ones;
  endfunction

  function automatic logic [15:0] model_frame(input logic [7:0] d);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
    if (PBITS != 0) f[1+DATA_BITS] = model_parity(d);
    f[1+DATA_BITS+PBITS] = 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // rx_done scoreboard
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rx_done) begin
        rx_done_seen++;
        checkOutput("rx_done_pulse", {31'd0, prev_done}, 32'd0);
        if (rx_exp.size() == 0) begin
          checkOutput("unexpected_rx_done", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
        end else begin
          rx_exp_t e;
          e = rx_exp.pop_front();
          checkOutput("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
          checkOutput("rx_frame_err", {31'd0, bus.rx_frame_err}, {31'd0, e.frame_err});
          checkOutput("rx_parity_err", {31'd0, bus.rx_parity_err}, {31'd0, e.parity_err});
        end
      end
      prev_done = bus.rx_done;
    end
  end

  // tx line decoder: samples mid-bit up to the first stop bit
  initial begin
    logic        tx_prev, active;
    int          cnt;
    logic [15:0] bits;
    tx_prev = 1'b1;
    active  = 1'b0;
    cnt     = 0;
    bits    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active  = 1'b0;
        tx_prev = 1'b1;
      end else begin
        if (!active && tx_prev && !tx) begin
          active = 1'b1;
          cnt    = 0;
          bits   = '0;
        end else if (active) begin
          cnt++;
          if (cnt % BIT_CLKS == BIT_CLKS / 2) begin
            bits[cnt / BIT_CLKS] = tx;
            if (cnt / BIT_CLKS == FRAME_BITS - STOP_BITS) begin
              active = 1'b0;
              if (tx_exp.size() == 0) checkOutput("unexpected_tx_frame", {16'd0, bits}, 32'hFFFF_FFFF);
              else checkOutput("tx_frame", {16'd0, bits}, {16'd0, model_frame(tx_exp.pop_front())});
            end
          end
        end
        tx_prev = tx;
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.tx_busy && n < 2 * FRAME_BITS * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (bus.tx_busy) checkOutput("tx_busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    rx_exp_t e;
    waitIdle();
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    e.data = d;
    e.frame_err = 1'b0;
    e.parity_err = 1'b0;
    tx_exp.push_back(d);
    rx_exp.push_back(e);
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic pulseStart(input logic [7:0] d);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic driveBit(input logic b);
    ext_rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic sendExt(input logic [7:0] d, input logic par_flip, input logic stop_val);
    rx_exp_t e;
    e.data = d;
    e.frame_err = !stop_val;
    e.parity_err = (PBITS != 0) && par_flip;
    rx_exp.push_back(e);
    ext_drive = 1'b1;
    driveBit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) driveBit(d[i]);
    if (PBITS != 0) driveBit(model_parity(d) ^ par_flip);
    driveBit(stop_val);
    driveBit(1'b1);
    ext_drive = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((rx_exp.size() != 0 || tx_exp.size() != 0) && n < 3 * FRAME_BITS * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (rx_exp.size() != 0 || tx_exp.size() != 0) begin
      checkOutput("drain_timeout", rx_exp.size() + tx_exp.size(), 32'd0);
      rx_exp.delete();
      tx_exp.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_len, exp_len, done_before;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    repeat (5) @(negedge clk);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("reset_rx_done", {31'd0, bus.rx_done}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    checkOutput("reset_errs", {30'd0, bus.rx_frame_err, bus.rx_parity_err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // loopback with busy-length measurement
    applyStimulus(8'hA5);
    checkOutput("start_tx_low", {31'd0, tx}, 32'd0);
    checkOutput("start_busy_high", {31'd0, bus.tx_busy}, 32'd1);
    busy_len = 0;
    while (bus.tx_busy && busy_len < 2 * FRAME_BITS * BIT_CLKS) begin
      busy_len++;
      @(negedge clk);
    end
    exp_len = FRAME_BITS * BIT_CLKS;
    tests_run++;
    if (busy_len < exp_len - 54 || busy_len > exp_len + 54) begin
      tests_failed++;
      $display("[TB] FAIL busy_len: got %0d clocks, expected %0d +-54", busy_len, exp_len);
    end
    waitDrain();

    // request while busy is ignored; next request on first idle cycle goes back-to-back
    applyStimulus(8'h11);
    repeat (100) @(negedge clk);
    pulseStart(8'h22);
    waitIdle();
    applyStimulus(8'h22);
    checkOutput("b2b_busy", {31'd0, bus.tx_busy}, 32'd1);
    waitDrain();

    sendExt(8'h3C, 1'b0, 1'b0);
    waitDrain();

    // glitch shorter than half a bit must not produce a frame
    done_before = rx_done_seen;
    ext_drive = 1'b1;
    ext_rx = 1'b0;
    repeat (200) @(negedge clk);
    ext_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    ext_drive = 1'b0;
    checkOutput("glitch_no_done", rx_done_seen, done_before);

`ifdef UART_PARITY_EN
    applyStimulus(8'h07);
    waitDrain();
    sendExt(8'h5C, 1'b1, 1'b1);
    waitDrain();
`endif

    for (int i = 0; i < NUM_RANDOM; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      if ($urandom_range(0, 1) == 0) applyStimulus(8'($urandom_range(0, 255)));
      else sendExt(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      waitDrain();
    end

    // reset in the middle of a transmitted frame
    applyStimulus(8'hC3);
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
    checkOutput("midreset_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("midreset_rx_done", {31'd0, bus.rx_done}, 32'd0);
    rx_exp.delete();
    tx_exp.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_before = rx_done_seen;
    repeat (BIT_CLKS) @(negedge clk);
    checkOutput("midreset_discard", rx_done_seen, done_before);
    applyStimulus(8'h5A);
    waitDrain();

    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("queues_empty", rx_exp.size() + tx_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
